// File: rtl/dma_block_copy.sv
// rtl/dma_block_copy.sv - block-copy DMA engine and CPU/DMA bus arbiter; optional completion IRQ under `DMA_IRQ_EN
module dma_block_copy #(
    parameter logic [7:0] CTRL_PAGE    = 8'h92,
    parameter int         GRANT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [7:0]  din_i,
    output logic [7:0]  dout_o,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_dout_i,
    input  logic        cpu_we_i,
    input  logic [7:0]  mem_din_i,
    output logic [15:0] bus_addr_o,
    output logic [7:0]  bus_dout_o,
    output logic        bus_we_o,
    output logic        cpu_rdy_o,
    output logic        dma_own_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_RD    = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // GRANT lasts one cycle for the CPU's in-flight access to retire, then GRANT_CYCLES idle cycles
    localparam logic [1:0] LP_GRANT_LAST = 2'(GRANT_CYCLES);

    localparam logic [7:0] LP_SRC_LO = 8'd0;
    localparam logic [7:0] LP_SRC_HI = 8'd1;
    localparam logic [7:0] LP_DST_LO = 8'd2;
    localparam logic [7:0] LP_DST_HI = 8'd3;
    localparam logic [7:0] LP_LEN_LO = 8'd4;
    localparam logic [7:0] LP_LEN_HI = 8'd5;
    localparam logic [7:0] LP_CTRL   = 8'd6;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [15:0] r_len;
    logic        r_done;
    logic [1:0]  r_gcnt;
    logic [7:0]  r_dout;

    logic        w_sel;
    logic        w_busy;
    logic        w_reg_wr;
    logic        w_start;
    logic        w_ctrl_rd;
    logic [7:0]  w_rdata;

    // Control-page decode; the page compare repeats the system decode so a stray en_i cannot hit registers
    assign w_sel     = en_i & (cpu_addr_i[15:8] == CTRL_PAGE);
    assign w_busy    = (r_state != S_IDLE);
    assign w_reg_wr  = w_sel & we_i & ~w_busy;
    assign w_start   = w_reg_wr & (addr_i == LP_CTRL) & din_i[0];
    assign w_ctrl_rd = w_sel & ~we_i & (addr_i == LP_CTRL);

    // Register read mux; live working registers are visible, unmapped offsets read zero
    always_comb begin
        w_rdata = 8'h00;
        case (addr_i)
            LP_SRC_LO: w_rdata = r_src[7:0];
            LP_SRC_HI: w_rdata = r_src[15:8];
            LP_DST_LO: w_rdata = r_dst[7:0];
            LP_DST_HI: w_rdata = r_dst[15:8];
            LP_LEN_LO: w_rdata = r_len[7:0];
            LP_LEN_HI: w_rdata = r_len[15:8];
            LP_CTRL:   w_rdata = {6'b0, r_done, w_busy};
            default:   w_rdata = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and bus arbitration; the CPU path is a pure pass-through whenever the DMA is not driving
    always_comb begin
        w_next     = r_state;
        cpu_rdy_o  = 1'b1;
        dma_own_o  = 1'b0;
        bus_addr_o = cpu_addr_i;
        bus_dout_o = cpu_dout_i;
        bus_we_o   = cpu_we_i;
        case (r_state)
            S_IDLE: begin
                if (w_start && (r_len != 16'd0)) begin
                    w_next = S_GRANT;
                end
            end
            S_GRANT: begin
                cpu_rdy_o = 1'b0;
                if (r_gcnt == LP_GRANT_LAST) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                cpu_rdy_o  = 1'b0;
                dma_own_o  = 1'b1;
                bus_addr_o = r_src;
                bus_dout_o = 8'h00;
                bus_we_o   = 1'b0;
                w_next     = S_WR;
            end
            S_WR: begin
                cpu_rdy_o  = 1'b0;
                dma_own_o  = 1'b1;
                bus_addr_o = r_dst;
                bus_dout_o = mem_din_i;
                bus_we_o   = 1'b1;
                w_next     = (r_len == 16'd1) ? S_DONE : S_RD;
            end
            S_DONE: begin
                // RDY returns high on the edge that leaves DONE
                cpu_rdy_o = 1'b0;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Grant idle-cycle counter, restarted every time GRANT is entered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gcnt <= 2'd0;
        end else if (r_state == S_GRANT) begin
            r_gcnt <= r_gcnt + 2'd1;
        end else begin
            r_gcnt <= 2'd0;
        end
    end

    // Programming registers double as the live copy pointers and remaining count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_src  <= 16'h0000;
            r_dst  <= 16'h0000;
            r_len  <= 16'h0000;
            r_done <= 1'b0;
        end else begin
            if (w_reg_wr) begin
                case (addr_i)
                    LP_SRC_LO: r_src[7:0]  <= din_i;
                    LP_SRC_HI: r_src[15:8] <= din_i;
                    LP_DST_LO: r_dst[7:0]  <= din_i;
                    LP_DST_HI: r_dst[15:8] <= din_i;
                    LP_LEN_LO: r_len[7:0]  <= din_i;
                    LP_LEN_HI: r_len[15:8] <= din_i;
                    default: ;
                endcase
            end
            if (r_state == S_WR) begin
                r_src <= r_src + 16'd1;
                r_dst <= r_dst + 16'd1;
                r_len <= r_len - 16'd1;
            end
            // A start clears done; a zero-length start completes immediately
            if (w_start) begin
                r_done <= (r_len == 16'd0);
            end else if (r_state == S_DONE) begin
                r_done <= 1'b1;
            end
        end
    end

    // Registered read data, updated on every control-page read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dout <= 8'h00;
        end else if (w_sel && !we_i) begin
            r_dout <= w_rdata;
        end
    end

    assign dout_o = r_dout;

`ifdef DMA_IRQ_EN
    logic r_irq;

    // Completion interrupt: set on the DONE edge (wins over a same-cycle clear), cleared by CTRL read or start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_irq <= 1'b1;
        end else if (w_ctrl_rd || w_start) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_o = r_irq;
`else
    logic w_unused_ctrl_rd;
    assign w_unused_ctrl_rd = w_ctrl_rd;
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_dma_block_copy.sv
// tb/tb_dma_block_copy.sv - self-checking bench for dma_block_copy
`timescale 1ns/1ps
module tb_dma_block_copy;
    localparam int G = 1;

    logic        clk = 1'b0;
    logic        rst_i, en_i, we_i, cpu_we_i, bus_we_o, cpu_rdy_o, dma_own_o, irq_o;
    logic [7:0]  addr_i, din_i, dout_o, cpu_dout_i, mem_din_i, bus_dout_o;
    logic [15:0] cpu_addr_i, bus_addr_o;

    always #5 clk = ~clk;

    dma_block_copy #(.CTRL_PAGE(8'h92), .GRANT_CYCLES(G)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .addr_i(addr_i), .din_i(din_i),
        .dout_o(dout_o), .cpu_addr_i(cpu_addr_i), .cpu_dout_i(cpu_dout_i), .cpu_we_i(cpu_we_i),
        .mem_din_i(mem_din_i), .bus_addr_o(bus_addr_o), .bus_dout_o(bus_dout_o), .bus_we_o(bus_we_o),
        .cpu_rdy_o(cpu_rdy_o), .dma_own_o(dma_own_o), .irq_o(irq_o));

    // system memory: 1-cycle read latency, control page not backed by RAM, backdoor preload port
    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus_we_o && bus_addr_o[15:8] != 8'h92) mem[bus_addr_o] <= bus_dout_o;
        mem_din_i <= mem[bus_addr_o];
    end

    int checks = 0;
    int failures = 0;
    int irq_high_seen = 0;

    always @(negedge clk) if (irq_o !== 1'b0) irq_high_seen <= irq_high_seen + 1;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        bit          poke;
        int          cyc;
        logic [15:0] src_end;
        logic [15:0] dst_end;
    } xfer_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        en_i = 1'b1; we_i = 1'b1; addr_i = a; din_i = d;
        cpu_addr_i = {8'h92, a}; cpu_dout_i = d; cpu_we_i = 1'b1;
        tick();
        en_i = 1'b0; we_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 16'h0000;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        en_i = 1'b1; we_i = 1'b0; addr_i = a; cpu_addr_i = {8'h92, a};
        tick();
        en_i = 1'b0; cpu_addr_i = 16'h0000;
        d = dout_o;
    endtask

    task automatic read16(input logic [7:0] off, output logic [15:0] v);
        logic [7:0] lo, hi;
        cpu_read(off, lo);
        cpu_read(off + 8'd1, hi);
        v = {hi, lo};
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        ref_mem[a] = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic set_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        cpu_write(8'd0, s[7:0]); cpu_write(8'd1, s[15:8]);
        cpu_write(8'd2, d[7:0]); cpu_write(8'd3, d[15:8]);
        cpu_write(8'd4, l[7:0]); cpu_write(8'd5, l[15:8]);
    endtask

    // fill source and destination (with a guard byte each side), then apply the copy to the model
    task automatic prepare(input logic [15:0] s, input logic [15:0] d, input int n, input int copied);
        for (int i = 0; i < n; i++) preload(s + 16'(i), 8'($urandom));
        for (int i = -1; i <= n; i++) preload(d + 16'(i), 8'($urandom));
        for (int i = 0; i < copied; i++) ref_mem[d + 16'(i)] = ref_mem[s + 16'(i)];
    endtask

    task automatic compare_mem(input string name, input logic [15:0] d, input int n);
        int errs = 0;
        for (int i = -1; i <= n; i++) if (mem[d + 16'(i)] !== ref_mem[d + 16'(i)]) errs++;
        check(name, errs, 0);
    endtask

    task automatic run_copy(input xfer_t t, input string tag);
        int low = 0, rdk = 0, wrk = 0, aerr = 0, derr = 0, irq_early = 0;
        logic [7:0]  r8;
        logic [15:0] r16;
        prepare(t.src, t.dst, int'(t.len), int'(t.len));
        set_regs(t.src, t.dst, t.len);
        cpu_write(8'd6, 8'h01);
        while (cpu_rdy_o === 1'b0 && low < 2000) begin
            if (dma_own_o === 1'b1) begin
                if (bus_we_o === 1'b0) begin
                    if (bus_addr_o !== t.src + 16'(rdk)) aerr++;
                    rdk++;
                end else begin
                    if (bus_addr_o !== t.dst + 16'(wrk)) aerr++;
                    if (bus_dout_o !== ref_mem[t.dst + 16'(wrk)]) derr++;
                    wrk++;
                end
            end
            if (irq_o !== 1'b0) irq_early++;
            if (low == 1) check({tag, "_ctrl_busy"}, dout_o, 8'h01);
            en_i = 1'b0; we_i = 1'b0;
            if (low == 0) begin
                en_i = 1'b1; addr_i = 8'd6; cpu_addr_i = 16'h9206;
            end else if (t.poke && low == 3) begin
                en_i = 1'b1; we_i = 1'b1; addr_i = 8'd0; din_i = 8'hAA; cpu_addr_i = 16'h9200;
            end else if (t.poke && low == 4) begin
                en_i = 1'b1; we_i = 1'b1; addr_i = 8'd6; din_i = 8'h01; cpu_addr_i = 16'h9206;
            end
            tick();
            low++;
        end
        en_i = 1'b0; we_i = 1'b0; cpu_addr_i = 16'h0000;
        check({tag, "_rdy_low_cycles"}, low, t.cyc);
        check({tag, "_bus_addr"}, aerr, 0);
        check({tag, "_bus_wdata"}, derr, 0);
        check({tag, "_reads"}, rdk, int'(t.len));
        check({tag, "_writes"}, wrk, int'(t.len));
`ifdef DMA_IRQ_EN
        check({tag, "_irq_early"}, irq_early, 0);
        check({tag, "_irq_set"}, irq_o, (t.len != 16'd0) ? 1 : 0);
`endif
        cpu_read(8'd6, r8);
        check({tag, "_ctrl_done"}, r8, 8'h02);
`ifdef DMA_IRQ_EN
        check({tag, "_irq_clr"}, irq_o, 0);
`endif
        read16(8'd0, r16); check({tag, "_src_end"}, r16, t.src_end);
        read16(8'd2, r16); check({tag, "_dst_end"}, r16, t.dst_end);
        read16(8'd4, r16); check({tag, "_len_end"}, r16, 16'h0000);
        compare_mem({tag, "_mem"}, t.dst, int'(t.len));
    endtask

    initial begin
        xfer_t       tbl [7];
        xfer_t       rx;
        logic [7:0]  r8;
        int          n;
        int          wrk;

        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        xfer_t       tbl [7];
        xfer_t       rx;
        logic [7:0]  r8;
        int          n;
        int          wrk;

        tbl[0] = '{16'h0100, 16'h8000, 16'd4, 1'b0, 11, 16'h0104, 16'h8004};
        tbl[1] = '{16'hFFFE, 16'h0010, 16'd3, 1'b0,  9, 16'h0001, 16'h0013};
        tbl[2] = '{16'h0200, 16'h0201, 16'd5, 1'b0, 13, 16'h0205, 16'h0206};
        tbl[3] = '{16'h0500, 16'h0600, 16'd0, 1'b0,  0, 16'h0500, 16'h0600};
        tbl[4] = '{16'h0300, 16'h8100, 16'd4, 1'b1, 11, 16'h0304, 16'h8104};
        tbl[5] = '{16'h0800, 16'h8400, 16'd2, 1'b0,  7, 16'h0802, 16'h8402};
        tbl[6] = '{16'h1234, 16'hFFFF, 16'd1, 1'b0,  5, 16'h1235, 16'h0000};

        rst_i = 1'b1; en_i = 1'b0; we_i = 1'b0; addr_i = 8'h00; din_i = 8'h00;
        cpu_addr_i = 16'h0000; cpu_dout_i = 8'h00; cpu_we_i = 1'b0;
        bd_we = 1'b0; bd_addr = 16'h0000; bd_data = 8'h00;
        tick(); tick(); tick();
        rst_i = 1'b0;

        check("rst_rdy", cpu_rdy_o, 1'b1);
        check("rst_own", dma_own_o, 1'b0);
        check("rst_bus_we", bus_we_o, 1'b0);
        check("rst_dout", dout_o, 8'h00);
        check("rst_irq", irq_o, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cpu_read(8'(i), r8);
            check($sformatf("rst_reg%0d", i), r8, 8'h00);
        end

        for (int i = 0; i < 3; i++) begin
            cpu_addr_i = 16'($urandom_range(0, 16'h8FFF));
            cpu_dout_i = 8'($urandom);
            cpu_we_i   = 1'b1;
            #1;
            check("pass_addr", bus_addr_o, cpu_addr_i);
            check("pass_dout", bus_dout_o, cpu_dout_i);
            check("pass_we", bus_we_o, 1'b1);
            cpu_we_i = 1'b0;
            tick();
        end

        for (int i = 0; i < 7; i++) run_copy(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 6; i++) begin
            rx.src = 16'($urandom);
            do rx.dst = 16'($urandom); while (rx.dst[15:8] >= 8'h91 && rx.dst[15:8] <= 8'h93);
            rx.len = 16'($urandom_range(1, 16));
            rx.poke = 1'b0;
            rx.cyc = 2 + G + 2 * int'(rx.len);
            rx.src_end = rx.src + rx.len;
            rx.dst_end = rx.dst + rx.len;
            run_copy(rx, $sformatf("rnd%0d", i));
        end

        prepare(16'h0700, 16'h8300, 4, 3);
        set_regs(16'h0700, 16'h8300, 16'd4);
        cpu_write(8'd6, 8'h01);
        n = 0; wrk = 0;
        while (n < 100) begin
            if (dma_own_o === 1'b1 && bus_we_o === 1'b1) begin
                if (wrk == 2) break;
                wrk++;
            end
            tick();
            n++;
        end
        check("rstmid_found_wr2", (n < 100) ? 1 : 0, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstmid_rdy", cpu_rdy_o, 1'b1);
        check("rstmid_own", dma_own_o, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cpu_read(8'(i), r8);
            check($sformatf("rstmid_reg%0d", i), r8, 8'h00);
        end
        compare_mem("rstmid_mem", 16'h8300, 4);

`ifndef DMA_IRQ_EN
        check("irq_const0", irq_high_seen, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
